hex_scan_controller: RTL and testbench
======================================

Name: hex_scan_controller

Overview:
- Avalon-MM-controlled scan driver that time-multiplexes four hex digits onto one shared active-low 7-segment bus with per-digit active-low enables.
- Display source is either the 16-bit hex-digits PIO output (hex_in) or an internal VALUE register.
- Provides leading-zero blanking, per-digit masking, a programmable scan rate and tear-free frame snapshots.
- Sits between the hex-digits PIO and the board display pins; the CPU configures it through its own slave.

Parameters:
DIV_W, 20, width of scan prescaler and DIV register
DIV_DEFAULT, 50000, reset value of DIV (clk cycles per digit slot)

Ports:
clk  input  1  system clock
reset_n  input  1  reset
address  input  2  Avalon word address
chipselect  input  1  Avalon select
write_n  input  1  Avalon write strobe, active-low
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, zero wait states
hex_in  input  16  four packed nibbles from hex-digits PIO; digit 0 = [3:0], rightmost
seg_n  output  7  {g,f,e,d,c,b,a}, active-low
dig_n  output  4  digit enables, active-low, one-hot-low when lit
frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Reset reset_n, asynchronous, active-low; clock clk. All state updates on posedge clk.
- Write = chipselect & ~write_n. readdata is combinational from address, unused bits 0.
- Register map:
  - 0 CTRL: bit0 EN (reset 1); bit1 LZB (reset 0); bit2 SRC, 0=hex_in, 1=VALUE (reset 0); bits7:4 MASK, 1=digit blanked (reset 0).
  - 1 VALUE: bits15:0, reset 0.
  - 2 DIV: bits DIV_W-1:0, reset DIV_DEFAULT. Write of 0 stores 1. Any DIV write also clears the prescaler to 0.
  - 3 STATUS: read-only; bits1:0 current digit idx, bits15:8 8-bit frame counter (wraps 255->0, reset 0). Writes ignored.
- Prescaler cnt:
  - Counts 0..DIV-1. tick = (cnt==DIV-1) & EN. On tick, cnt<=0 and idx<=idx+1 mod 4.
  - DIV=1 gives a tick every cycle.
- Frame start: a tick with idx==3 (3->0 wrap). On that tick:
  - shadow <= selected source (hex_in or VALUE, per SRC at that cycle);
  - frame_tick pulses the next cycle;
  - frame counter increments.
- shadow resets to 0. Source and CTRL.LZB changes affect the display only from the next frame. EN and MASK take effect immediately.
- Outputs are registered and update the cycle after a tick or register write (1-cycle latency):
  - dig_n[i]=0 only when i==idx, EN=1, digit i not masked and not LZB-blanked.
  - seg_n = decode(shadow nibble idx) when lit, else 7'h7F.
- LZB: digit i (i=3,2,1) blanked if LZB=1 and shadow nibbles 3..i are all 0. Digit 0 is never LZB-blanked.
- A blanked or masked digit still consumes its time slot (constant duty cycle).
- Decode (seg_n hex), 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- EN=0: cnt and idx held at 0, no ticks, dig_n=F, seg_n=7F, frame counter frozen.
- EN 0->1: scanning restarts at digit 0 with cnt=0. shadow is not reloaded until the first wrap, so the first frame shows the old shadow.
- Simultaneous DIV write and tick: the write wins (cnt<=0), the tick is still taken that cycle, and idx advances.
- Reset mid-frame: all state returns to reset values immediately; outputs are seg_n=7F, dig_n=F, frame_tick=0.

Test Plan:
- Reset, then write DIV=4, hex_in=16'h1A2F -> after first wrap, each digit slot lasts 4 cycles. Sequence: dig_n=E,seg_n=0E; dig_n=D,seg_n=24; dig_n=B,seg_n=08; dig_n=7,seg_n=79. frame_tick pulses once per 16 cycles.
- CTRL LZB=1, hex_in=16'h0005, DIV=2 -> digits 3,2,1 dig_n held at 1 during their slots, digit 0 shows seg_n=12. With hex_in=0, only digit 0 is lit, seg_n=40.
- SRC=1, VALUE=16'hBEEF, change hex_in mid-frame -> display switches to BEEF only after the next frame_tick. Reading address 1 returns 32'h0000BEEF.
- Write DIV=0 -> reading address 2 returns 1, a tick occurs every cycle, idx cycles 0,1,2,3 on consecutive cycles.
- MASK=4'b0101, then EN=0 mid-frame -> digits 0 and 2 dark in their slots. After EN=0: next cycle dig_n=F, seg_n=7F, STATUS idx=0, frame counter stops.
- Assert reset_n low mid-slot -> seg_n=7F, dig_n=F asynchronously. Reading address 2 returns DIV_DEFAULT, address 0 returns 1.

Source files
------------

// File: rtl/hex_scan_controller.sv
// Purpose: drive four hex digits onto one shared active-low 7-segment bus, with an Avalon-MM slave for configuration.
// Latency: the display outputs are registered and follow a slot tick or a register write by one clk.
// Backpressure: none; the slave has zero wait states and readdata is combinational from address.
module hex_scan_controller #(
  parameter int DIV_W       = 20,
  parameter int DIV_DEFAULT = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] hex_in,
  output logic [6:0]  seg_n,
  output logic [3:0]  dig_n,
  output logic        frame_tick
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

  // Register-map state
  logic             en, lzb, src;
  logic [3:0]       mask;
  logic [15:0]      value;
  logic [DIV_W-1:0] div;

  // Scan state
  logic [DIV_W-1:0] cnt;
  logic [1:0]       idx;
  logic [7:0]       frame_cnt;
  logic [15:0]      shadow;
  logic             lzb_act;   // LZB as latched at the last frame start

  // Next-state values
  logic             en_nxt, lzb_nxt, src_nxt;
  logic [3:0]       mask_nxt;
  logic [15:0]      value_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [1:0]       idx_nxt;
  logic [7:0]       frame_cnt_nxt;
  logic [15:0]      shadow_nxt;
  logic             lzb_act_nxt;
  logic [6:0]       seg_nxt;
  logic [3:0]       dig_nxt;

  logic wr, wr_ctrl, wr_value, wr_div;
  logic tick, frame_start;

  // Only the low DIV_W/16 bits of writedata matter; the rest are ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr       = chipselect & ~write_n;
  assign wr_ctrl  = wr & (address == 2'd0);
  assign wr_value = wr & (address == 2'd1);
  assign wr_div   = wr & (address == 2'd2);

  assign tick        = en & (cnt == div - 1'b1);
  assign frame_start = tick & (idx == 2'd3);

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Register-map writes; a DIV of zero is stored as one so the prescaler always wraps
  always_comb begin
    en_nxt    = en;
    lzb_nxt   = lzb;
    src_nxt   = src;
    mask_nxt  = mask;
    value_nxt = value;
    div_nxt   = div;
    if (wr_ctrl) begin
      en_nxt   = writedata[0];
      lzb_nxt  = writedata[1];
      src_nxt  = writedata[2];
      mask_nxt = writedata[7:4];
    end
    if (wr_value) begin
      value_nxt = writedata[15:0];
    end
    if (wr_div) begin
      div_nxt = (writedata[DIV_W-1:0] == '0) ? DIV_W'(1) : writedata[DIV_W-1:0];
    end
  end

  // Prescaler and digit index; a DIV write clears cnt but a coincident tick still advances idx,
  // and a disabled scanner (or one being enabled/disabled this cycle) parks at digit 0, cnt 0
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    if (tick) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end
    if (wr_div) begin
      cnt_nxt = '0;
    end
    if (!en || !en_nxt) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end
  end

  // Frame start snapshots the source and LZB so a frame is never torn
  always_comb begin
    shadow_nxt    = shadow;
    lzb_act_nxt   = lzb_act;
    frame_cnt_nxt = frame_cnt;
    if (frame_start) begin
      shadow_nxt    = src ? value : hex_in;
      lzb_act_nxt   = lzb;
      frame_cnt_nxt = frame_cnt + 8'd1;
    end
  end

  // Display for the state being entered, so the output registers track it with one clk of latency
  always_comb begin
    logic [3:0] nib;
    logic [3:0] lz_blank;
    logic       z3, z32, z321;
    logic       lit;
    case (idx_nxt)
      2'd0:    nib = shadow_nxt[3:0];
      2'd1:    nib = shadow_nxt[7:4];
      2'd2:    nib = shadow_nxt[11:8];
      default: nib = shadow_nxt[15:12];
    endcase
    z3   = (shadow_nxt[15:12] == 4'h0);
    z32  = z3  & (shadow_nxt[11:8] == 4'h0);
    z321 = z32 & (shadow_nxt[7:4]  == 4'h0);
    lz_blank = {z3, z32, z321, 1'b0} & {4{lzb_act_nxt}};
    lit = en_nxt & ~mask_nxt[idx_nxt] & ~lz_blank[idx_nxt];
    seg_nxt = lit ? hex_decode(nib) : 7'h7F;
    dig_nxt = lit ? ~(4'b0001 << idx_nxt) : 4'hF;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en         <= 1'b1;
      lzb        <= 1'b0;
      src        <= 1'b0;
      mask       <= 4'h0;
      value      <= 16'h0000;
      div        <= DIV_RST;
      cnt        <= '0;
      idx        <= 2'd0;
      frame_cnt  <= 8'd0;
      shadow     <= 16'h0000;
      lzb_act    <= 1'b0;
      seg_n      <= 7'h7F;
      dig_n      <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      en         <= en_nxt;
      lzb        <= lzb_nxt;
      src        <= src_nxt;
      mask       <= mask_nxt;
      value      <= value_nxt;
      div        <= div_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      frame_cnt  <= frame_cnt_nxt;
      shadow     <= shadow_nxt;
      lzb_act    <= lzb_act_nxt;
      seg_n      <= seg_nxt;
      dig_n      <= dig_nxt;
      frame_tick <= frame_start;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[7:0] = {mask, 1'b0, src, lzb, en};
      2'd1: readdata[15:0] = value;
      2'd2: readdata[DIV_W-1:0] = div;
      default: readdata[15:0] = {frame_cnt, 6'b0, idx};
    endcase
  end

endmodule

// File: tb/tb_hex_scan_controller.sv
// Randomized bench for hex_scan_controller against a behavioural model of the scan display.
module tb_hex_scan_controller;

  localparam int DIV_W       = 20;
  localparam int DIV_DEFAULT = 50000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] hex_in;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_tick;

  hex_scan_controller #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .hex_in(hex_in),
    .seg_n(seg_n), .dig_n(dig_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behavioural model
  bit          m_en, m_lzb, m_src, m_lzba, m_ft;
  logic [3:0]  m_mask;
  logic [15:0] m_value, m_shadow;
  int          m_div, m_cnt, m_idx, m_fc;
  logic [6:0]  m_seg;
  logic [3:0]  m_dig;

  task automatic model_reset();
    m_en = 1; m_lzb = 0; m_src = 0; m_lzba = 0; m_ft = 0;
    m_mask = 4'h0; m_value = 16'h0; m_shadow = 16'h0;
    m_div = DIV_DEFAULT; m_cnt = 0; m_idx = 0; m_fc = 0;
    m_seg = 7'h7F; m_dig = 4'hF;
  endtask

  // A digit is dark when disabled, masked, or when it and everything left of it is zero under LZB.
  task automatic model_display();
    int  nib;
    bit  lit;
    nib = (int'(m_shadow) >> (4 * m_idx)) & 15;
    lit = m_en && !m_mask[m_idx] &&
          !(m_lzba && m_idx > 0 && (int'(m_shadow) >> (4 * m_idx)) == 0);
    m_seg = lit ? seg_tab[nib] : 7'h7F;
    m_dig = lit ? 4'(~(1 << m_idx)) : 4'hF;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_mask, 1'b0, m_src, m_lzb, m_en};
      2'd1:    return {16'h0, m_value};
      2'd2:    return 32'(m_div);
      default: return 32'((m_fc << 8) | m_idx);
    endcase
  endfunction

  task automatic model_step();
    bit wr, tick, frame, old_en;
    int n_cnt, n_idx, wv;
    wr    = chipselect && !write_n;
    tick  = m_en && (m_cnt == m_div - 1);
    frame = tick && (m_idx == 3);
    n_cnt = m_cnt + 1;
    n_idx = m_idx;
    if (frame) begin
      m_shadow = m_src ? m_value : hex_in;
      m_lzba   = m_lzb;
      m_fc     = (m_fc + 1) % 256;
    end
    m_ft = frame;
    if (tick) begin
      n_cnt = 0;
      n_idx = (m_idx + 1) % 4;
    end
    old_en = m_en;
    if (wr) begin
      case (address)
        2'd0: begin
          m_en = writedata[0]; m_lzb = writedata[1]; m_src = writedata[2]; m_mask = writedata[7:4];
        end
        2'd1: m_value = writedata[15:0];
        2'd2: begin
          wv = int'(writedata[DIV_W-1:0]);
          m_div = (wv == 0) ? 1 : wv;
          n_cnt = 0;
        end
        default: ;
      endcase
    end
    if (!old_en || !m_en) begin
      n_cnt = 0;
      n_idx = 0;
    end
    m_cnt = n_cnt;
    m_idx = n_idx;
    model_display();
  endtask

  // One clock: inputs are already driven (just after a negedge); check the read port, step, check outputs.
  task automatic do_cycle();
    #1;
    check("readdata", readdata, model_read(address));
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("seg_n", {25'h0, seg_n}, {25'h0, m_seg});
    check("dig_n", {28'h0, dig_n}, {28'h0, m_dig});
    check("frame_tick", {31'h0, frame_tick}, {31'h0, m_ft});
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) begin
      chipselect = 0; write_n = 1; address = a;
      do_cycle();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    do_cycle();
    chipselect = 0; write_n = 1;
  endtask

  task automatic read_const(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  logic [15:0] zmask [5] = '{16'h0000, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};

  initial begin
    logic [31:0] wd;
    int r;
    reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; hex_in = 16'h0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_seg", {25'h0, seg_n}, 32'h7F);
    check("rst_dig", {28'h0, dig_n}, 32'hF);
    check("rst_ft", {31'h0, frame_tick}, 32'h0);
    read_const("rst_ctrl", 2'd0, 32'h1);
    read_const("rst_div", 2'd2, 32'(DIV_DEFAULT));
    read_const("rst_status", 2'd3, 32'h0);
    reset_n = 1;
    model_reset();

    // DIV=4 with 1A2F: F,2,A,1 on digits 0..3, four clocks per slot
    hex_in = 16'h1A2F;
    bus_write(2'd2, 32'd4);
    for (int i = 0; i < 48; i++) begin
      chipselect = 0; write_n = 1; address = 2'd3;
      do_cycle();
      if (i >= 20) begin
        case (dig_n)
          4'hE: check("s1_d0", {25'h0, seg_n}, 32'h0E);
          4'hD: check("s1_d1", {25'h0, seg_n}, 32'h24);
          4'hB: check("s1_d2", {25'h0, seg_n}, 32'h08);
          4'h7: check("s1_d3", {25'h0, seg_n}, 32'h79);
          default: check("s1_dig_lit", {28'h0, dig_n}, 32'hE);
        endcase
      end
    end

    // Leading-zero blanking
    bus_write(2'd0, 32'h3);
    bus_write(2'd2, 32'd2);
    hex_in = 16'h0005;
    idle(24, 2'd3);
    hex_in = 16'h0000;
    idle(24, 2'd0);

    // VALUE source, hex_in changes mid-frame
    bus_write(2'd1, 32'hFFFF_BEEF);
    bus_write(2'd0, 32'h5);
    idle(5, 2'd1);
    hex_in = 16'h1234;
    idle(20, 2'd3);
    read_const("value_rb", 2'd1, 32'h0000_BEEF);

    // DIV=0 stores 1
    bus_write(2'd2, 32'h0);
    read_const("div0_rb", 2'd2, 32'h1);
    idle(10, 2'd3);

    // Mask digits 0 and 2, then disable mid-frame
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h51);
    idle(18, 2'd3);
    bus_write(2'd0, 32'h50);
    idle(8, 2'd3);
    bus_write(2'd0, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 15);
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) hex_in = 16'($urandom) & zmask[$urandom_range(0, 4)];
      case (r)
        0: begin if ($urandom_range(0, 5) != 0) wd[0] = 1'b1; bus_write(2'd0, wd); end
        1: bus_write(2'd1, wd & {16'h0, zmask[$urandom_range(0, 4)]});
        2: bus_write(2'd2, (wd & 32'hFFF0_0000) | 32'($urandom_range(0, 5)));
        3: bus_write(2'd3, wd);
        default: begin
          chipselect = 1'($urandom_range(0, 1));
          write_n = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
          address = 2'($urandom_range(0, 3));
          writedata = wd;
          do_cycle();
        end
      endcase
    end

    // Asynchronous reset in the middle of a slot
    chipselect = 0; write_n = 1;
    bus_write(2'd0, 32'h1);
    bus_write(2'd2, 32'd5);
    idle(7, 2'd3);
    #2;
    reset_n = 0;
    #1;
    check("arst_seg", {25'h0, seg_n}, 32'h7F);
    check("arst_dig", {28'h0, dig_n}, 32'hF);
    check("arst_ft", {31'h0, frame_tick}, 32'h0);
    read_const("arst_ctrl", 2'd0, 32'h1);
    read_const("arst_div", 2'd2, 32'(DIV_DEFAULT));
    model_reset();
    @(negedge clk);
    reset_n = 1;
    bus_write(2'd2, 32'd1);
    idle(12, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
